bin_to_bcd_display: RTL and testbench
=====================================

Name: bin_to_bcd_display

Overview:
Iterative double-dabble converter that turns a binary word, such as a register or PC value, into packed BCD digits. It sits directly upstream of the seven-segment digit-scan block and drives its 32-bit data_to_display input, so values appear in decimal on the 8-digit display. It processes one bit per cycle to keep area small, and uses a start/busy/done handshake.

Parameters:
BIN_W, 32, width of binary input (>=1)
DIGITS, 8, number of BCD digits produced (>=1); bcd_out width = 4*DIGITS

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  request conversion of bin_in; sampled on rising clk
bin_in  input  BIN_W  unsigned binary value; captured only on accepted start
busy  output  1  conversion in progress
done  output  1  one-cycle pulse; bcd_out/overflow updated this cycle
bcd_out  output  4*DIGITS  packed BCD result, digit 0 in [3:0]; held between conversions
overflow  output  1  value >= 10^DIGITS; held with bcd_out

Behaviour:
- Interface: clock clk; reset reset, asynchronous, active-high.
- Reset values: state IDLE; busy=0, done=0, bcd_out=0, overflow=0; internal shift/work regs cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k → capture bin_in into shift reg, clear BCD work reg and sticky overflow bit, load bit counter = BIN_W, go to SHIFT.
- SHIFT:
  - busy=1.
  - Each cycle, first add 3 to every work digit >= 5, then shift {work, shift_reg} left by 1.
  - The bit shifted out of the top digit ORs into the sticky overflow bit.
  - Counter decrements each cycle; after BIN_W shift cycles go to DONE.
- DONE:
  - Lasts one cycle. done=1, busy=0.
  - At the edge entering DONE, bcd_out and overflow are loaded from the work reg and sticky bit.
- Latency: start sampled at edge k → busy high cycles k+1..k+BIN_W → done high in cycle k+BIN_W+1. With defaults, done arrives 33 cycles after start.
- Handshake:
  - start is accepted whenever busy=0, including the DONE cycle, so back-to-back starts go straight from DONE to SHIFT.
  - start while busy=1 is ignored, and a later bin_in change has no effect.
  - start held high continuously produces repeated conversions, one every BIN_W+1 cycles.
- Width rules:
  - Counter width is clog2(BIN_W+1).
  - Digit adjust is a 4-bit add with no carry between digits.
  - Without overflow, bcd_out equals the exact decimal value of bin_in.
- Overflow: if any 1 is shifted out of the top digit, overflow=1 and the result is handled as described under Optional Feature.
- Reset mid-conversion: aborts immediately; bcd_out/overflow clear to 0; no done pulse is generated.
- bcd_out changes only at the DONE-entry edge or on reset, so the downstream display never shows intermediate values.

Optional Feature:
Macro BCD_SATURATE_EN.
- Defined: when overflow=1, bcd_out is forced to all nines (for example 0x99999999 with defaults).
- Undefined: bcd_out holds the low DIGITS digits, i.e. value mod 10^DIGITS.
- overflow flag behaviour is identical in both builds.

Test Plan:
1. Reset, then start with bin_in=0 → done exactly 33 cycles after the start edge, bcd_out=0x00000000, overflow=0; busy high for exactly 32 cycles.
2. bin_in=12345678 → bcd_out=0x12345678, overflow=0; bcd_out unchanged from its prior value during busy.
3. bin_in=99999999 → 0x99999999, ov=0. Then bin_in=100000000 → ov=1, bcd_out=0x00000000 (macro off) or 0x99999999 (macro on).
4. bin_in=0xFFFFFFFF → ov=1, bcd_out=0x94967295 (macro off) or 0x99999999 (macro on).
5. start=1 with bin_in=42, then re-pulse start with bin_in=7 at cycle 5 → ignored, result 0x00000042. Start with 7 asserted on the done cycle → accepted, done 33 cycles later with 0x00000007.
6. Assert reset at cycle 10 of a conversion of 555 → busy/done/bcd_out/overflow all 0 immediately, no done pulse. After release, start with 555 → 0x00000555.

Source files
------------

// File: rtl/bin_to_bcd_display_if.sv
// +--------------------------------------------------------------------+
// | bin_to_bcd_display_if : start/busy/done handshake and result bus   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface bin_to_bcd_display_if #(
   parameter int BIN_W  = 32,
   parameter int DIGITS = 8
);
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  overflow;

   modport master (output start, bin_in, input busy, done, bcd_out, overflow);
   modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
endinterface

`default_nettype wire

// File: rtl/bin_to_bcd_display.sv
// +--------------------------------------------------------------------+
// | bin_to_bcd_display : iterative double-dabble, one bit per cycle    |
// | Option: BCD_SATURATE_EN forces all nines on overflow. Rev: 1.0     |
// +--------------------------------------------------------------------+
`default_nettype none

module bin_to_bcd_display #(
   parameter int BIN_W  = 32,
   parameter int DIGITS = 8
) (
   input  wire logic          clk,
   input  wire logic          reset,
   bin_to_bcd_display_if.slave bus
);
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [BIN_W-1:0]   r_shift;
   logic [BCD_W-1:0]   r_work;
   logic               r_sticky;
   logic [CNT_W-1:0]   r_cnt;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_ovf;

   logic               w_load;
   logic               w_shift;
   logic               w_finish;
   logic               w_busy;
   logic               w_done;
   logic [BCD_W-1:0]   w_adj;
   logic [BCD_W-1:0]   w_work_nxt;
   logic               w_sticky_nxt;
   logic [BCD_W-1:0]   w_bcd_res;

   // Per-digit add-3 with no carry between digits.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_work[4*gi +: 4] >= 4'd5) ?
                                (r_work[4*gi +: 4] + 4'd3) : r_work[4*gi +: 4];
   end

   assign w_work_nxt   = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
   assign w_sticky_nxt = r_sticky | w_adj[BCD_W-1];

`ifdef BCD_SATURATE_EN
   assign w_bcd_res = w_sticky_nxt ? {DIGITS{4'h9}} : w_work_nxt;
`else
   assign w_bcd_res = w_work_nxt;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_finish    = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_busy  = 1'b1;
            w_shift = 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               w_finish    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = S_SHIFT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The result registers move only on the final shift, so the display never sees partial work.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift  <= '0;
         r_work   <= '0;
         r_sticky <= 1'b0;
         r_cnt    <= '0;
         r_bcd    <= '0;
         r_ovf    <= 1'b0;
      end else if (w_load) begin
         r_shift  <= bus.bin_in;
         r_work   <= '0;
         r_sticky <= 1'b0;
         r_cnt    <= CNT_W'(BIN_W);
      end else if (w_shift) begin
         r_shift  <= r_shift << 1;
         r_work   <= w_work_nxt;
         r_sticky <= w_sticky_nxt;
         r_cnt    <= r_cnt - CNT_W'(1);
         if (w_finish) begin
            r_bcd <= w_bcd_res;
            r_ovf <= w_sticky_nxt;
         end
      end
   end

   assign bus.busy     = w_busy;
   assign bus.done     = w_done;
   assign bus.bcd_out  = r_bcd;
   assign bus.overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_display.sv
// +--------------------------------------------------------------------+
// | tb_bin_to_bcd_display : directed table plus handshake/reset cases  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_bin_to_bcd_display;
   localparam int BIN_W  = 32;
   localparam int DIGITS = 8;
   localparam int LAT    = BIN_W + 1;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   bin_to_bcd_display_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   bin_to_bcd_display #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] bin;
      logic [31:0] bcd_mod;
      logic        ovf;
   } vec_t;

   vec_t vt[10];

   function automatic logic [31:0] exp_bcd(input logic [31:0] m, input logic ov);
`ifdef BCD_SATURATE_EN
      return ov ? 32'h99999999 : m;
`else
      return m;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive start for one cycle; returns at #1 after the accepting edge.
   task automatic start_conv(input logic [31:0] b);
      bus.start  = 1'b1;
      bus.bin_in = b;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.bin_in = $urandom;
   endtask

   // i0 is the cycle index already reached after the start edge (1 = first cycle).
   task automatic wait_done(input string name, input int i0, input logic [31:0] eb, input logic eo);
      int          i;
      int          busy_n;
      bit          moved;
      logic [31:0] prev;
      i      = i0;
      busy_n = i0 - 1;
      moved  = 1'b0;
      prev   = bus.bcd_out;
      while (!bus.done && i < 100) begin
         if (bus.busy) busy_n++;
         if (bus.bcd_out !== prev) moved = 1'b1;
         @(posedge clk);
         #1;
         i++;
      end
      chk({name, "_done_seen"}, 64'(bus.done), 64'd1);
      chk({name, "_latency"},   64'(i), 64'(LAT));
      chk({name, "_busy_cyc"},  64'(busy_n), 64'(BIN_W));
      chk({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      chk({name, "_held"},      64'(moved), 64'd0);
      chk({name, "_bcd"},       64'(bus.bcd_out), 64'(eb));
      chk({name, "_ovf"},       64'(bus.overflow), 64'(eo));
   endtask

   initial begin
      int          n;
      int          gap;
      bit          seen_done;
      total      = 0;
      bad        = 0;
      bus.start  = 1'b0;
      bus.bin_in = '0;
      reset      = 1'b1;

      vt[0] = '{32'd0,          32'h00000000, 1'b0};
      vt[1] = '{32'd12345678,   32'h12345678, 1'b0};
      vt[2] = '{32'd99999999,   32'h99999999, 1'b0};
      vt[3] = '{32'd100000000,  32'h00000000, 1'b1};
      vt[4] = '{32'd1,          32'h00000001, 1'b0};
      vt[5] = '{32'd10,         32'h00000010, 1'b0};
      vt[6] = '{32'd1234567890, 32'h34567890, 1'b1};
      vt[7] = '{32'd59,         32'h00000059, 1'b0};
      vt[8] = '{32'd80808080,   32'h80808080, 1'b0};
      vt[9] = '{32'hFFFFFFFF,   32'h94967295, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_bcd",  64'(bus.bcd_out), 64'd0);
      chk("rst_ovf",  64'(bus.overflow), 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int k = 0; k < 10; k++) begin
         start_conv(vt[k].bin);
         wait_done($sformatf("vec%0d", k), 1, exp_bcd(vt[k].bcd_mod, vt[k].ovf), vt[k].ovf);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_idle", k), 64'({bus.busy, bus.done}), 64'd0);
      end

      // start while busy is ignored; start during the DONE cycle is accepted.
      start_conv(32'd42);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      bus.start  = 1'b1;
      bus.bin_in = 32'd7;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.bin_in = 32'd999;
      wait_done("ignore", 5, 32'h00000042, 1'b0);
      start_conv(32'd7);
      chk("b2b_busy", 64'(bus.busy), 64'd1);
      wait_done("b2b", 1, 32'h00000007, 1'b0);

      // Held start: conversions repeat every BIN_W+1 cycles.
      bus.start  = 1'b1;
      bus.bin_in = 32'd321;
      n = 0;
      while (!bus.done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      gap = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 100 && !seen_done; c++) begin
         @(posedge clk);
         #1;
         gap++;
         if (bus.done) seen_done = 1'b1;
      end
      bus.start = 1'b0;
      chk("held_seen", 64'(seen_done), 64'd1);
      chk("held_gap",  64'(gap), 64'(LAT));
      chk("held_bcd",  64'(bus.bcd_out), 64'h321);
      @(posedge clk);
      #1;

      // Prior result is nonzero with overflow, so the reset clear is visible.
      start_conv(32'hFFFFFFFF);
      wait_done("pre_rst", 1, exp_bcd(32'h94967295, 1'b1), 1'b1);
      start_conv(32'd555);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_done", 64'(bus.done), 64'd0);
      chk("mid_rst_bcd",  64'(bus.bcd_out), 64'd0);
      chk("mid_rst_ovf",  64'(bus.overflow), 64'd0);
      seen_done = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) seen_done = 1'b1;
      end
      chk("no_done_after_rst", 64'(seen_done), 64'd0);
      start_conv(32'd555);
      wait_done("post_rst", 1, 32'h00000555, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
